// File: rtl/iobus_target_mux.sv
// MicroBlaze MCS IO bus mux: decodes per-target address windows, forwards strobes,
// and returns the selected target's response or a default one on unmapped/timeout.
module iobus_target_mux #(
    parameter logic [31:0] BASE_ADDRESS      = 32'hC0000000,
    parameter logic [31:0] ADDRESS_STRIDE    = 32'h00001000,
    parameter int          TARGET_COUNT      = 4,
    parameter int          TIMEOUT_CYCLES    = 16,
    parameter logic [31:0] DEFAULT_READ_DATA = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         io_addr_strobe,
    input  logic [31:0]                  io_address,
    input  logic [3:0]                   io_byte_enable,
    input  logic                         io_read_strobe,
    input  logic                         io_write_strobe,
    input  logic [31:0]                  io_write_data,
    output logic [31:0]                  io_read_data,
    output logic                         io_ready,
    output logic [TARGET_COUNT-1:0]      tgt_addr_strobe,
    output logic [TARGET_COUNT-1:0]      tgt_read_strobe,
    output logic [TARGET_COUNT-1:0]      tgt_write_strobe,
    output logic [31:0]                  tgt_address,
    output logic [3:0]                   tgt_byte_enable,
    output logic [31:0]                  tgt_write_data,
    input  logic [32*TARGET_COUNT-1:0]   tgt_read_data,
    input  logic [TARGET_COUNT-1:0]      tgt_ready,
    output logic                         timeout_pulse,
    output logic                         unmapped_pulse,
    output logic [7:0]                   error_count
);

    localparam int SW = (TARGET_COUNT > 1) ? $clog2(TARGET_COUNT) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic            ioReady_q;
    logic [31:0]     ioReadData_q;
    logic            timeoutPulse_q;
    logic            unmappedPulse_q;
    logic [7:0]      errorCount_q;

    logic [TARGET_COUNT-1:0] hitVec;
    logic [SW-1:0]           hitIdx_d;
    logic                    reserved;
    logic                    unmapped;
    logic                    accepted;
    logic                    acceptStrobe;
    logic [31:0]             selData;
    logic                    selReady;

    // Window bounds are computed in 33 bits so the top window cannot wrap past 4 GiB.
    for (genvar i = 0; i < TARGET_COUNT; i++) begin : g_decode
        localparam logic [32:0] LO = 33'(BASE_ADDRESS) + 33'(ADDRESS_STRIDE) * 33'(i);
        localparam logic [32:0] HI = LO + 33'(ADDRESS_STRIDE);
        assign hitVec[i] = !reserved && ({1'b0, io_address} >= LO) && ({1'b0, io_address} < HI);
    end

    assign reserved     = (io_address[31:29] == 3'b111);
    assign unmapped     = !reserved && !(|hitVec);
    assign accepted     = (state_q == IDLE);
    assign acceptStrobe = accepted && io_addr_strobe;

    assign tgt_addr_strobe  = hitVec & {TARGET_COUNT{acceptStrobe}};
    assign tgt_read_strobe  = hitVec & {TARGET_COUNT{acceptStrobe && io_read_strobe}};
    assign tgt_write_strobe = hitVec & {TARGET_COUNT{acceptStrobe && io_write_strobe}};
    assign tgt_address      = io_address & (ADDRESS_STRIDE - 32'd1);
    assign tgt_byte_enable  = io_byte_enable;
    assign tgt_write_data   = io_write_data;

    always_comb begin
        hitIdx_d = '0;
        selData  = '0;
        selReady = 1'b0;
        for (int i = 0; i < TARGET_COUNT; i++) begin
            if (hitVec[i]) hitIdx_d = SW'(i);
            if (sel_q == SW'(i)) begin
                selData  = tgt_read_data[32*i +: 32];
                selReady = tgt_ready[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            cnt_q           <= '0;
            ioReady_q       <= 1'b0;
            ioReadData_q    <= '0;
            timeoutPulse_q  <= 1'b0;
            unmappedPulse_q <= 1'b0;
            errorCount_q    <= '0;
        end else begin
            ioReady_q       <= 1'b0;
            timeoutPulse_q  <= 1'b0;
            unmappedPulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io_addr_strobe && |hitVec) begin
                        sel_q   <= hitIdx_d;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (io_addr_strobe && unmapped) begin
                        ioReady_q       <= 1'b1;
                        ioReadData_q    <= DEFAULT_READ_DATA;
                        unmappedPulse_q <= 1'b1;
                        if (errorCount_q != 8'hFF) errorCount_q <= errorCount_q + 8'd1;
                    end
                end
                WAIT: begin
                    // A real answer beats a timeout landing on the same cycle.
                    if (selReady) begin
                        ioReady_q    <= 1'b1;
                        ioReadData_q <= selData;
                        state_q      <= IDLE;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        ioReady_q      <= 1'b1;
                        ioReadData_q   <= DEFAULT_READ_DATA;
                        timeoutPulse_q <= 1'b1;
                        state_q        <= IDLE;
                        if (errorCount_q != 8'hFF) errorCount_q <= errorCount_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_ready       = ioReady_q;
    assign io_read_data   = ioReadData_q;
    assign timeout_pulse  = timeoutPulse_q;
    assign unmapped_pulse = unmappedPulse_q;
    assign error_count    = errorCount_q;

endmodule

// File: tb/tb_iobus_target_mux.sv
// Directed bench for iobus_target_mux with four targets and a 16-cycle timeout.
module tb_iobus_target_mux;

    logic         clk;
    logic         rst_n;
    logic         io_addr_strobe;
    logic [31:0]  io_address;
    logic [3:0]   io_byte_enable;
    logic         io_read_strobe;
    logic         io_write_strobe;
    logic [31:0]  io_write_data;
    logic [31:0]  io_read_data;
    logic         io_ready;
    logic [3:0]   tgt_addr_strobe;
    logic [3:0]   tgt_read_strobe;
    logic [3:0]   tgt_write_strobe;
    logic [31:0]  tgt_address;
    logic [3:0]   tgt_byte_enable;
    logic [31:0]  tgt_write_data;
    logic [127:0] tgt_read_data;
    logic [3:0]   tgt_ready;
    logic         timeout_pulse;
    logic         unmapped_pulse;
    logic [7:0]   error_count;

    int nAsserts = 0;
    int nFail    = 0;

    iobus_target_mux #(
        .BASE_ADDRESS(32'hC0000000),
        .ADDRESS_STRIDE(32'h1000),
        .TARGET_COUNT(4),
        .TIMEOUT_CYCLES(16),
        .DEFAULT_READ_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_addr_strobe(io_addr_strobe),
        .io_address(io_address),
        .io_byte_enable(io_byte_enable),
        .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_write_data(io_write_data),
        .io_read_data(io_read_data),
        .io_ready(io_ready),
        .tgt_addr_strobe(tgt_addr_strobe),
        .tgt_read_strobe(tgt_read_strobe),
        .tgt_write_strobe(tgt_write_strobe),
        .tgt_address(tgt_address),
        .tgt_byte_enable(tgt_byte_enable),
        .tgt_write_data(tgt_write_data),
        .tgt_read_data(tgt_read_data),
        .tgt_ready(tgt_ready),
        .timeout_pulse(timeout_pulse),
        .unmapped_pulse(unmapped_pulse),
        .error_count(error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle starts 1ns after a rising edge; registered outputs are stable then.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic strobe, input logic [31:0] addr,
                                 input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        io_addr_strobe  = strobe;
        io_address      = addr;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_byte_enable  = be;
        io_write_data   = wdata;
        #1;
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        tgt_ready     = 4'h0;
        tgt_read_data = '0;
        idleBus();
        tick();
        tick();
        checkOutput("rst_ready", 32'(io_ready), 32'd0);
        checkOutput("rst_rdata", io_read_data, 32'h0);
        checkOutput("rst_tmo", 32'(timeout_pulse), 32'd0);
        checkOutput("rst_unm", 32'(unmapped_pulse), 32'd0);
        checkOutput("rst_errcnt", 32'(error_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read target 2, answer at N+3; other targets' ready at N+2 must be ignored.
        applyStimulus(1'b1, 32'hC0002014, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("t2_astb", 32'(tgt_addr_strobe), 32'h4);
        checkOutput("t2_rstb", 32'(tgt_read_strobe), 32'h4);
        checkOutput("t2_wstb", 32'(tgt_write_strobe), 32'h0);
        checkOutput("t2_addr", tgt_address, 32'h014);
        tick();
        idleBus();
        checkOutput("t2_n1_ready", 32'(io_ready), 32'd0);
        tick();
        tgt_ready = 4'b1011;
        tgt_read_data[31:0] = 32'h11111111;
        tick();
        checkOutput("t2_n3_ready", 32'(io_ready), 32'd0);
        tgt_ready = 4'b0100;
        tgt_read_data[95:64] = 32'h12345678;
        tick();
        tgt_ready = 4'h0;
        checkOutput("t2_n4_ready", 32'(io_ready), 32'd1);
        checkOutput("t2_n4_rdata", io_read_data, 32'h12345678);

        // Write to the top of target 3 in the same cycle as the previous io_ready.
        applyStimulus(1'b1, 32'hC0003FFC, 1'b0, 1'b1, 4'b0011, 32'hA5A5A5A5);
        checkOutput("t3_wstb", 32'(tgt_write_strobe), 32'h8);
        checkOutput("t3_astb", 32'(tgt_addr_strobe), 32'h8);
        checkOutput("t3_rstb", 32'(tgt_read_strobe), 32'h0);
        checkOutput("t3_addr", tgt_address, 32'hFFC);
        checkOutput("t3_wdata", tgt_write_data, 32'hA5A5A5A5);
        checkOutput("t3_be", 32'(tgt_byte_enable), 32'h3);
        tick();
        idleBus();
        checkOutput("t3_ready_early", 32'(io_ready), 32'd0);
        tgt_ready = 4'b1000;
        tgt_read_data[127:96] = 32'h0BADF00D;
        tick();
        tgt_ready = 4'h0;
        checkOutput("t3_ready", 32'(io_ready), 32'd1);
        checkOutput("t3_rdata", io_read_data, 32'h0BADF00D);
        tick();
        checkOutput("t3_ready_drop", 32'(io_ready), 32'd0);

        // Two unmapped reads back to back.
        applyStimulus(1'b1, 32'hC0004000, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("unm1_astb", 32'(tgt_addr_strobe), 32'h0);
        tick();
        checkOutput("unm1_ready", 32'(io_ready), 32'd1);
        checkOutput("unm1_rdata", io_read_data, 32'hDEADBEEF);
        checkOutput("unm1_pulse", 32'(unmapped_pulse), 32'd1);
        applyStimulus(1'b1, 32'h00000010, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("unm2_astb", 32'(tgt_addr_strobe), 32'h0);
        tick();
        idleBus();
        checkOutput("unm2_ready", 32'(io_ready), 32'd1);
        checkOutput("unm2_pulse", 32'(unmapped_pulse), 32'd1);
        tick();
        checkOutput("unm_errcnt", 32'(error_count), 32'd2);
        checkOutput("unm_pulse_drop", 32'(unmapped_pulse), 32'd0);

        // Reserved segment: silence.
        applyStimulus(1'b1, 32'hE0000000, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("rsv_astb", 32'(tgt_addr_strobe), 32'h0);
        checkOutput("rsv_rstb", 32'(tgt_read_strobe), 32'h0);
        tick();
        idleBus();
        checkOutput("rsv_ready", 32'(io_ready), 32'd0);
        checkOutput("rsv_unm", 32'(unmapped_pulse), 32'd0);
        tick();
        checkOutput("rsv_errcnt", 32'(error_count), 32'd2);

        // Target 1 never answers: timeout at N+17.
        applyStimulus(1'b1, 32'hC0001000, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("tmo_astb", 32'(tgt_addr_strobe), 32'h2);
        tick();
        idleBus();
        repeat (15) tick();
        checkOutput("tmo_n16_ready", 32'(io_ready), 32'd0);
        tick();
        checkOutput("tmo_ready", 32'(io_ready), 32'd1);
        checkOutput("tmo_rdata", io_read_data, 32'hDEADBEEF);
        checkOutput("tmo_pulse", 32'(timeout_pulse), 32'd1);
        tick();
        checkOutput("tmo_pulse_drop", 32'(timeout_pulse), 32'd0);
        checkOutput("tmo_errcnt", 32'(error_count), 32'd3);

        // Target 1 answers on the last possible cycle: response beats timeout.
        applyStimulus(1'b1, 32'hC0001008, 1'b1, 1'b0, 4'hF, 32'h0);
        tick();
        idleBus();
        repeat (15) tick();
        tgt_ready = 4'b0010;
        tgt_read_data[63:32] = 32'hCAFE0001;
        tick();
        tgt_ready = 4'h0;
        checkOutput("late_ready", 32'(io_ready), 32'd1);
        checkOutput("late_rdata", io_read_data, 32'hCAFE0001);
        checkOutput("late_tmo", 32'(timeout_pulse), 32'd0);
        tick();
        checkOutput("late_errcnt", 32'(error_count), 32'd3);

        // Strobe during WAIT is dropped; wrong-target ready ignored.
        applyStimulus(1'b1, 32'hC0001000, 1'b1, 1'b0, 4'hF, 32'h0);
        tick();
        applyStimulus(1'b1, 32'hC0000000, 1'b1, 1'b0, 4'hF, 32'h0);
        checkOutput("viol_astb", 32'(tgt_addr_strobe), 32'h0);
        tick();
        idleBus();
        tgt_ready = 4'b0001;
        tgt_read_data[31:0] = 32'h22222222;
        tick();
        checkOutput("viol_ready", 32'(io_ready), 32'd0);
        tgt_ready = 4'b0010;
        tgt_read_data[63:32] = 32'h33333333;
        tick();
        tgt_ready = 4'h0;
        checkOutput("viol_done", 32'(io_ready), 32'd1);
        checkOutput("viol_rdata", io_read_data, 32'h33333333);
        tick();
        checkOutput("viol_errcnt", 32'(error_count), 32'd3);

        // Reset while waiting abandons the access.
        applyStimulus(1'b1, 32'hC0002000, 1'b1, 1'b0, 4'hF, 32'h0);
        tick();
        idleBus();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rstw_ready", 32'(io_ready), 32'd0);
        checkOutput("rstw_rdata", io_read_data, 32'h0);
        checkOutput("rstw_errcnt", 32'(error_count), 32'd0);
        checkOutput("rstw_tmo", 32'(timeout_pulse), 32'd0);
        tgt_ready = 4'b0100;
        tick();
        tgt_ready = 4'h0;
        checkOutput("rstw_noresp", 32'(io_ready), 32'd0);

        // 300 unmapped reads saturate the error counter.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, 32'h00001000 + 32'(k), 1'b1, 1'b0, 4'hF, 32'h0);
            tick();
        end
        idleBus();
        tick();
        tick();
        checkOutput("sat_errcnt", 32'(error_count), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
